// File: rtl/msk_pkg.sv
// msk_pkg: shared constants, FSM state type and LFSR feedback for the masking encoder.
package msk_pkg;
    localparam int LFSR_W        = 64;
    localparam int TAP0          = 63;
    localparam int TAP1          = 62;
    localparam int TAP2          = 60;
    localparam int TAP3          = 59;
    localparam int WARMUP_CYCLES = 4;
    typedef enum logic [1:0] {ST_UNSEEDED, ST_WARMUP, ST_RUN} state_t;
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
    endfunction
endpackage

// File: rtl/msk_lfsr_prng.sv
// msk_lfsr_prng: seedable 64-bit Fibonacci LFSR emitting R fresh bits per advance.
module msk_lfsr_prng
    import msk_pkg::*;
#(
    parameter int R = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    output logic [R-1:0]      o_rbits
);
    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;
    logic [R-1:0]      w_rbits;
    // R steps unrolled; bit j is the feedback of step j
    always_comb begin
        w_next  = r_state;
        w_rbits = '0;
        for (int j = 0; j < R; j++) begin
            w_rbits[j] = lfsr_fb(w_next);
            w_next     = {w_next[LFSR_W-2:0], w_rbits[j]};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LFSR_W'(1);
        else if (i_load) r_state <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        else if (i_adv) r_state <= w_next;
    end
    assign o_rbits = w_rbits;
endmodule

// File: rtl/msk_share_encoder.sv
// msk_share_encoder: turns unmasked N-bit words into d-share Boolean sharings,
// with masks drawn from an internal PRNG; ready/valid on both sides, latency 1.
module msk_share_encoder
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              prng_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*d-1:0]    out_shares
);
    localparam int R = N * (d - 1);
    localparam int CW = $clog2(WARMUP_CYCLES);
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [N*d-1:0]  r_shares;
    logic [N*d-1:0]  w_shares;
    logic [R-1:0]    w_rbits;
    logic            w_accept;
    logic            w_adv;
    // A seed load wins over an input transfer in the same cycle
    assign in_ready   = (r_state == ST_RUN) && !seed_valid && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_adv      = w_accept || ((r_state == ST_WARMUP) && !seed_valid);
    assign prng_ready = (r_state == ST_RUN);
    assign out_valid  = r_out_valid;
    assign out_shares = r_shares;
    msk_lfsr_prng #(.R(R)) u_prng (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (seed_valid),
        .i_seed (seed),
        .i_adv  (w_adv),
        .o_rbits(w_rbits)
    );
    always_comb begin
        w_shares = '0;
        for (int i = 0; i < N; i++) begin
            w_shares[i*d] = in_data[i];
            for (int k = 1; k < d; k++) begin
                w_shares[i*d+k] = w_rbits[i*(d-1)+k-1];
                w_shares[i*d]   = w_shares[i*d] ^ w_rbits[i*(d-1)+k-1];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNSEEDED;
            r_cnt   <= '0;
        end else if (seed_valid) begin
            r_state <= ST_WARMUP;
            r_cnt   <= '0;
        end else if (r_state == ST_WARMUP) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= (r_cnt == CW'(WARMUP_CYCLES - 1)) ? ST_RUN : ST_WARMUP;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_shares    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_shares    <= w_shares;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_msk_share_encoder.sv
// tb_msk_share_encoder: directed and table-driven checks of the share encoder
// against an independent LFSR/encoding model (d=2,N=8 and d=3,N=4 instances).
module tb_msk_share_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_seed_valid, a_prng_ready, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_seed;
    logic [7:0]  a_in_data;
    logic [15:0] a_out_shares;
    logic        b_seed_valid, b_prng_ready, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_seed;
    logic [3:0]  b_in_data;
    logic [11:0] b_out_shares;

    msk_share_encoder #(.d(2), .N(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .seed_valid(a_seed_valid), .seed(a_seed),
        .prng_ready(a_prng_ready), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_shares(a_out_shares)
    );
    msk_share_encoder #(.d(3), .N(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_valid(b_seed_valid), .seed(b_seed),
        .prng_ready(b_prng_ready), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_shares(b_out_shares)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
    } vec_t;
    vec_t tbl[16];

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] ma, mb, rb;
    logic [15:0] qa[$];
    logic [11:0] qb[$];
    logic [3:0]  qd[$];
    int          ones[8];
    int          cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] adv(input logic [63:0] s, input int r, output logic [63:0] bits);
        logic fb;
        bits = '0;
        for (int j = 0; j < r; j++) begin
            fb = s[63] ^ s[62] ^ s[60] ^ s[59];
            bits[j] = fb;
            s = {s[62:0], fb};
        end
        return s;
    endfunction

    function automatic logic [63:0] warm(input logic [63:0] sd, input int r);
        logic [63:0] s, t;
        s = (sd == 64'h0) ? 64'h1 : sd;
        for (int w = 0; w < 4; w++) s = adv(s, r, t);
        return s;
    endfunction

    function automatic logic [15:0] enc2(input logic [7:0] dt, input logic [63:0] bits);
        logic [15:0] o;
        for (int i = 0; i < 8; i++) begin
            o[2*i+1] = bits[i];
            o[2*i]   = dt[i] ^ bits[i];
        end
        return o;
    endfunction

    function automatic logic [11:0] enc3(input logic [3:0] dt, input logic [63:0] bits);
        logic [11:0] o;
        for (int i = 0; i < 4; i++) begin
            o[3*i+1] = bits[2*i];
            o[3*i+2] = bits[2*i+1];
            o[3*i]   = dt[i] ^ bits[2*i] ^ bits[2*i+1];
        end
        return o;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    // Pulses seed_valid for one cycle, then counts cycles until prng_ready
    task automatic seed_a(input logic [63:0] sd, input string nm);
        int cnt;
        a_seed_valid = 1'b1;
        a_seed = sd;
        tick;
        a_seed_valid = 1'b0;
        ma = warm(sd, 8);
        cnt = 1;
        while (!a_prng_ready && cnt < 20) begin
            tick;
            cnt++;
        end
        check(nm, cnt, 5);
    endtask

    // Accepts one word, checks it against the model (and a hand value if given), drains it
    task automatic send_a(input logic [7:0] dt, input string nm, input bit use_hc, input logic [15:0] hc);
        logic [15:0] e;
        logic [7:0]  x;
        a_in_valid = 1'b1;
        a_in_data = dt;
        a_out_ready = 1'b0;
        #1;
        check({nm, "_in_ready"}, a_in_ready, 1);
        ma = adv(ma, 8, rb);
        e = enc2(dt, rb);
        tick;
        a_in_valid = 1'b0;
        check({nm, "_out_valid"}, a_out_valid, 1);
        check(nm, a_out_shares, e);
        for (int i = 0; i < 8; i++) x[i] = a_out_shares[2*i] ^ a_out_shares[2*i+1];
        check({nm, "_xor"}, x, dt);
        if (use_hc) check({nm, "_hand"}, a_out_shares, hc);
        a_out_ready = 1'b1;
        tick;
        check({nm, "_drained"}, a_out_valid, 0);
    endtask

    task automatic stream_a(input bit toggle, output int cycles);
        int sent, recv;
        logic acc, drn, pv;
        logic [15:0] ps;
        sent = 0;
        recv = 0;
        cycles = 0;
        while (recv < 16 && cycles < 200) begin
            a_in_valid = (sent < 16);
            a_in_data = tbl[(sent < 16) ? sent : 0].data;
            a_out_ready = toggle ? tbl[cycles % 16].rdy : 1'b1;
            #1;
            acc = a_in_valid && a_in_ready;
            drn = a_out_valid && a_out_ready;
            pv = a_out_valid;
            ps = a_out_shares;
            if (drn) begin
                check("stream_word", a_out_shares, (qa.size() > 0) ? qa.pop_front() : 16'hxxxx);
                recv++;
            end
            if (acc) begin
                ma = adv(ma, 8, rb);
                qa.push_back(enc2(a_in_data, rb));
                sent++;
            end
            tick;
            if (pv && !drn) begin
                check("stall_hold", a_out_shares, ps);
                check("stall_valid", a_out_valid, 1);
            end
            cycles++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("stream_recv", recv, 16);
        check("stream_sent", sent, 16);
    endtask

    initial begin
        logic [15:0] e;
        logic [3:0]  x;
        int cnt, sent, recv, k;
        for (int i = 0; i < 16; i++) begin
            tbl[i].data = 8'(i * 8'h1D + 8'h3);
            tbl[i].rdy = (i % 3 != 1);
        end
        tbl[0].data = 8'h00;
        tbl[15].data = 8'hFF;
        rst_n = 1'b0;
        a_seed_valid = 0; a_seed = '0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_seed_valid = 0; b_seed = '0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        tick;
        tick;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_shares", a_out_shares, 0);
        check("rst_prng_ready", a_prng_ready, 0);
        check("rst_in_ready", a_in_ready, 0);
        rst_n = 1'b1;
        a_in_valid = 1'b1;
        a_in_data = 8'hA5;
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("unseeded_idle", {a_in_ready, a_out_valid, a_prng_ready}, 3'b000);
        end
        a_in_valid = 1'b0;

        // Seeds 0 and 1 are identical; the first word carries all-zero masks
        seed_a(64'h0, "warmup_seed0");
        send_a(8'hA5, "a5_seed0", 1'b1, 16'h4411);
        seed_a(64'h1, "warmup_seed1");
        send_a(8'hA5, "a5_seed1", 1'b1, 16'h4411);
        seed_a(64'h0123456789ABCDEF, "warmup_seed_main");
        send_a(8'hA5, "a5_main", 1'b0, 16'h0);

        stream_a(1'b0, cnt);
        check("stream_throughput", cnt, 17);
        stream_a(1'b1, cnt);
        send_a(8'h5A, "post_stream", 1'b0, 16'h0);

        // Reseed while an output is pending and stalled
        a_in_valid = 1'b1;
        a_in_data = 8'h3C;
        a_out_ready = 1'b0;
        #1;
        check("pend_in_ready", a_in_ready, 1);
        ma = adv(ma, 8, rb);
        e = enc2(8'h3C, rb);
        tick;
        a_in_data = 8'hFF;
        a_seed_valid = 1'b1;
        a_seed = 64'hFEDCBA9876543210;
        #1;
        check("reseed_in_ready", a_in_ready, 0);
        tick;
        a_seed_valid = 1'b0;
        a_in_valid = 1'b0;
        ma = warm(64'hFEDCBA9876543210, 8);
        check("reseed_pend_valid", a_out_valid, 1);
        check("reseed_pend_shares", a_out_shares, e);
        check("reseed_prng_low", a_prng_ready, 0);
        a_out_ready = 1'b1;
        tick;
        check("reseed_drained", a_out_valid, 0);
        cnt = 2;
        while (!a_prng_ready && cnt < 20) begin
            tick;
            cnt++;
        end
        check("reseed_warmup_len", cnt, 5);
        send_a(8'hC3, "after_reseed", 1'b0, 16'h0);

        // d=3, N=4 instance: back-to-back 0/F words, mask bit frequencies
        b_seed_valid = 1'b1;
        b_seed = 64'hDEADBEEFCAFEF00D;
        tick;
        b_seed_valid = 1'b0;
        mb = warm(64'hDEADBEEFCAFEF00D, 8);
        cnt = 1;
        while (!b_prng_ready && cnt < 20) begin
            tick;
            cnt++;
        end
        check("b_warmup_len", cnt, 5);
        for (int p = 0; p < 8; p++) ones[p] = 0;
        sent = 0;
        recv = 0;
        cyc = 0;
        b_out_ready = 1'b1;
        while (recv < 1000 && cyc < 1100) begin
            b_in_valid = (sent < 1000);
            b_in_data = sent[0] ? 4'hF : 4'h0;
            #1;
            if (b_out_valid && b_out_ready) begin
                for (int i = 0; i < 4; i++) x[i] = ^b_out_shares[3*i +: 3];
                check("b_xor", x, (qd.size() > 0) ? qd.pop_front() : 4'hx);
                check("b_model", b_out_shares, (qb.size() > 0) ? qb.pop_front() : 12'hxxx);
                for (int i = 0; i < 4; i++) begin
                    ones[2*i] += b_out_shares[3*i+1];
                    ones[2*i+1] += b_out_shares[3*i+2];
                end
                recv++;
            end
            if (b_in_valid && b_in_ready) begin
                mb = adv(mb, 8, rb);
                qb.push_back(enc3(b_in_data, rb));
                qd.push_back(b_in_data);
                sent++;
            end
            tick;
            cyc++;
        end
        b_in_valid = 1'b0;
        check("b_recv", recv, 1000);
        for (int p = 0; p < 8; p++) begin
            k = ones[p];
            check($sformatf("b_freq_pos%0d_count%0d", p, k), (k >= 450 && k <= 550), 1);
        end

        // Reset mid-operation drops a pending output
        a_in_valid = 1'b1;
        a_in_data = 8'h11;
        a_out_ready = 1'b0;
        tick;
        a_in_valid = 1'b0;
        check("mid_pend_valid", a_out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_shares", a_out_shares, 0);
        check("mid_rst_prng", a_prng_ready, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("mid_rst_unseeded", a_in_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/msk_share_encoder.md
Name: msk_share_encoder

Overview:
- Converts unmasked N-bit words into d-share Boolean sharings for the masked datapath. Sharings use the same layout the gadgets consume: d adjacent share bits per logical bit.
- Generates its own fresh masks from an internal seedable 64-bit LFSR.
- Sits at the datapath boundary, upstream of every masked gadget: it produces sharings, while the gadgets consume sharings and randomness.
- Ready/valid handshake on both sides; one registered output stage, latency 1.

Parameters:
- d, 2, masking order + 1 (number of shares); d >= 2
- N, 8, number of logical bits encoded per transfer

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- seed_valid  input  1  load seed into the PRNG this cycle
- seed  input  64  PRNG seed value
- prng_ready  output  1  high when the FSM is in RUN
- in_valid  input  1  in_data is valid
- in_ready  output  1  encoder accepts in_data this cycle
- in_data  input  N  unmasked word
- out_valid  output  1  out_shares is valid
- out_ready  input  1  downstream accepts out_shares
- out_shares  output  N*d  sharing; out_shares[i*d +: d] holds the shares of bit i

Behaviour:
- Reset (async assert, sync release):
  - FSM=UNSEEDED, lfsr=64'h1, warm counter=0
  - out_valid=0, out_shares=0, prng_ready=0, in_ready=0
- R = N*(d-1) random bits are consumed per encoding.
- LFSR step:
  - fb = s[63]^s[62]^s[60]^s[59]
  - s <= {s[62:0], fb}
  - The emitted bit is fb.
- LFSR advance: one advance applies R steps in the same cycle (combinationally unrolled). Random bit j is the fb of step j, j=0..R-1.
- Mask assignment: for bit i and share k = 1..d-1:
  - out_shares[i*d+k] = rbit[i*(d-1)+k-1]
  - out_shares[i*d+0] = in_data[i] XOR (xor of shares 1..d-1)
- FSM:
  - UNSEEDED: in_ready=0. seed_valid -> load lfsr (seed==0 loads 64'h1), counter=0, go to WARMUP.
  - WARMUP: advance the LFSR every cycle; counter counts 0..3; after the 4th advance go to RUN. seed_valid reloads the seed and restarts the counter at 0.
  - RUN: prng_ready=1. seed_valid -> reload the seed, go to WARMUP. Seed load has priority over an input transfer in the same cycle, so in_ready is forced to 0 that cycle.
- Handshake:
  - in_ready = RUN && !seed_valid && (!out_valid || out_ready)
  - Accept (in_valid && in_ready): register the sharing, out_valid <= 1, LFSR advances once.
  - out_valid && out_ready && no accept: out_valid <= 0, out_shares held.
  - Simultaneous output drain and input accept: a new word is loaded; back-to-back throughput is 1 word/cycle.
- out_shares and out_valid are stable while out_valid && !out_ready, independent of seed activity. A pending output survives a reseed and drains normally.
- The LFSR advances only on accept or in WARMUP, never on idle cycles.
- Asserting rst_n low mid-operation drops any pending output immediately (out_valid=0).

Decomposition:
- Shared package msk_pkg: LFSR width 64, tap constants (63,62,60,59), WARMUP_CYCLES=4, FSM state enum.
- One sub-module, msk_lfsr_prng (parameter R): holds the state, load/advance controls, R-bit output.

Test Plan:
- Reset, no seed; drive in_valid=1 -> in_ready=0, out_valid=0, prng_ready=0 indefinitely.
- d=2, N=8, seed=64'h0123456789ABCDEF, wait for prng_ready (exactly 5 cycles after seed_valid).
  - Send 8'hA5 -> out_valid next cycle; XOR of each share pair equals 8'hA5.
  - Shares 1 match a golden model of the LFSR.
- seed=0 -> behaves identically to seed=64'h1; the golden model must match bit-exactly.
- Stream 16 words with out_ready held 1 -> 16 consecutive out_valid cycles.
  - Toggle out_ready 1/0 -> out_shares holds while stalled; no word is lost or duplicated.
  - The LFSR advances exactly 16 times.
- Assert seed_valid together with in_valid while an output is pending and stalled:
  - no input is accepted that cycle;
  - the pending output is unchanged and drains;
  - prng_ready=0 for 4 cycles, then resumes.
- d=3, N=4, all inputs 4'h0 and 4'hF -> each triple XORs to its bit. Over 1000 transfers, each random share position is 1 with frequency 0.45–0.55.
